// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl_pkg
// Description : Shared types and constants for the hazard controller and
//               the pipeline registers it drives.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_ctrl_pkg;

    localparam int C_REG_AW = 5;
    localparam logic [31:0] C_NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_detect.sv
`default_nettype none
// ============================================================================
// Module      : hazard_detect
// Description : Combinational load-use comparator between EX and ID stages.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_detect
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = C_REG_AW
) (
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    output logic              lu
);

    logic w_rd_nz;
    logic w_rs_hit;
    logic w_rt_hit;

    // r0 is hardwired to zero, so a load targeting it never creates a dependency
    assign w_rd_nz  = (ex_rd != '0);
    assign w_rs_hit = (ex_rd == id_rs);
    assign w_rt_hit = id_uses_rt & (ex_rd == id_rt);
    assign lu       = ex_mem_read & w_rd_nz & (w_rs_hit | w_rt_hit);

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Load-use stall and branch/jump flush controller. Define
//               HAZARD_PERF_CNT_EN to add stall/flush performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int LOAD_LAT = 1,
    parameter int REG_AW   = C_REG_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    input  logic              ex_branch_taken,
    input  logic              id_jump,
    output logic              pc_hazard,
    output logic              ifid_hold,
    output logic              ifid_flush,
    output logic              idex_bubble,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt,
`endif
    output logic [1:0]        dbg_state
);

    localparam logic [2:0] C_LAT_M1 = 3'(LOAD_LAT - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_cnt;
    logic [2:0] w_cnt_nxt;
    logic       w_lu;
    logic       w_haz;
    logic       w_hold;
    logic       w_flush;
    logic       w_bub;

    hazard_detect #(
        .REG_AW (REG_AW)
    ) u_detect (
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .lu          (w_lu)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= RUN;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_haz       = 1'b0;
        w_hold      = 1'b0;
        w_flush     = 1'b0;
        w_bub       = 1'b0;
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        // A taken branch wins in every state and cancels any pending stall
        if (ex_branch_taken) begin
            w_flush     = 1'b1;
            w_bub       = 1'b1;
            w_state_nxt = FLUSH;
            w_cnt_nxt   = 3'd0;
        end else begin
            case (r_state)
                STALL: begin
                    w_haz  = 1'b1;
                    w_hold = 1'b1;
                    w_bub  = 1'b1;
                    if (r_cnt <= 3'd1) begin
                        w_state_nxt = RUN;
                        w_cnt_nxt   = 3'd0;
                    end else begin
                        w_cnt_nxt = r_cnt - 3'd1;
                    end
                end
                FLUSH: begin
                    w_bub       = 1'b1;
                    w_state_nxt = RUN;
                end
                default: begin
                    w_state_nxt = RUN;
                    if (id_jump) begin
                        w_flush = 1'b1;
                    end else if (w_lu) begin
                        w_haz  = 1'b1;
                        w_hold = 1'b1;
                        w_bub  = 1'b1;
                        if (LOAD_LAT > 1) begin
                            w_state_nxt = STALL;
                            w_cnt_nxt   = C_LAT_M1;
                        end
                    end
                end
            endcase
        end
    end

    assign pc_hazard   = rst & w_haz;
    assign ifid_hold   = rst & w_hold;
    assign ifid_flush  = rst & w_flush;
    assign idex_bubble = rst & w_bub;
    assign dbg_state   = r_state;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cnt <= 32'd0;
            r_flush_cnt <= 32'd0;
        end else begin
            if (pc_hazard)  r_stall_cnt <= r_stall_cnt + 32'd1;
            if (ifid_flush) r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Directed table-driven bench for hazard_ctrl (LOAD_LAT 2 and 3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rd;
    logic       id_uses_rt, ex_mem_read, ex_branch_taken, id_jump;

    logic       haz2, hold2, flush2, bub2;
    logic [1:0] st2;
    logic       haz3, hold3, flush3, bub3;
    logic [1:0] st3;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] sc2, fc2, sc3, fc3;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.LOAD_LAT(2), .REG_AW(5)) u_dut2 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .id_jump(id_jump), .pc_hazard(haz2), .ifid_hold(hold2), .ifid_flush(flush2),
        .idex_bubble(bub2),
`ifdef HAZARD_PERF_CNT_EN
        .stall_cnt(sc2), .flush_cnt(fc2),
`endif
        .dbg_state(st2)
    );

    hazard_ctrl #(.LOAD_LAT(3), .REG_AW(5)) u_dut3 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .id_jump(id_jump), .pc_hazard(haz3), .ifid_hold(hold3), .ifid_flush(flush3),
        .idex_bubble(bub3),
`ifdef HAZARD_PERF_CNT_EN
        .stall_cnt(sc3), .flush_cnt(fc3),
`endif
        .dbg_state(st3)
    );

    typedef struct {
        logic       r;
        logic [4:0] rs, rt;
        logic       urt;
        logic [4:0] rd;
        logic       mr, br, jmp;
        logic [5:0] exp;   // {haz, hold, flush, bub, state[1:0]}
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                                input logic urt, input logic [4:0] rd, input logic mr,
                                input logic br, input logic jmp, input logic [5:0] exp);
        vec_t v;
        v.r = r; v.rs = rs; v.rt = rt; v.urt = urt; v.rd = rd;
        v.mr = mr; v.br = br; v.jmp = jmp; v.exp = exp;
        return v;
    endfunction

    task automatic drive(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urt, input logic [4:0] rd, input logic mr,
                         input logic br, input logic jmp);
        rst = r; id_rs = rs; id_rt = rt; id_uses_rt = urt; ex_rd = rd;
        ex_mem_read = mr; ex_branch_taken = br; id_jump = jmp;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    int hz;

    initial begin
        //                r  rs rt u rd mr br j   haz hold flush bub st
        vecs[0]  = mk(0, 5, 0, 0, 5, 1, 1, 0, 6'b0000_00);
        vecs[1]  = mk(0, 5, 0, 0, 5, 1, 1, 1, 6'b0000_00);
        vecs[2]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 6'b0000_00);
        vecs[3]  = mk(1, 5, 0, 0, 5, 1, 0, 0, 6'b1101_00);
        vecs[4]  = mk(1, 5, 0, 0, 5, 1, 0, 0, 6'b1101_01);
        vecs[5]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 6'b0000_00);
        vecs[6]  = mk(1, 0, 0, 0, 0, 1, 0, 0, 6'b0000_00);
        vecs[7]  = mk(1, 3, 7, 1, 7, 1, 0, 0, 6'b1101_00);
        vecs[8]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 6'b1101_01);
        vecs[9]  = mk(1, 3, 7, 0, 7, 1, 0, 0, 6'b0000_00);
        vecs[10] = mk(1, 0, 0, 0, 0, 0, 1, 0, 6'b0011_00);
        vecs[11] = mk(1, 0, 0, 0, 0, 0, 0, 0, 6'b0001_10);
        vecs[12] = mk(1, 5, 0, 0, 5, 1, 1, 1, 6'b0011_00);
        vecs[13] = mk(1, 5, 0, 0, 5, 1, 0, 1, 6'b0001_10);
        vecs[14] = mk(1, 0, 0, 0, 0, 0, 0, 1, 6'b0010_00);
        vecs[15] = mk(1, 0, 0, 0, 0, 0, 0, 0, 6'b0000_00);
        vecs[16] = mk(1, 9, 0, 0, 9, 1, 0, 0, 6'b1101_00);
        vecs[17] = mk(0, 9, 0, 0, 9, 1, 0, 0, 6'b0000_01);
        vecs[18] = mk(1, 0, 0, 0, 0, 0, 0, 0, 6'b0000_00);
        vecs[19] = mk(1, 0, 0, 0, 0, 0, 1, 0, 6'b0011_00);
        vecs[20] = mk(1, 0, 0, 0, 0, 0, 1, 0, 6'b0011_10);
        vecs[21] = mk(1, 0, 0, 0, 0, 0, 0, 0, 6'b0001_10);
        vecs[22] = mk(1, 0, 0, 0, 0, 0, 0, 0, 6'b0000_00);

        drive(0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].r, vecs[i].rs, vecs[i].rt, vecs[i].urt, vecs[i].rd,
                  vecs[i].mr, vecs[i].br, vecs[i].jmp);
            @(negedge clk);
            chk($sformatf("vec%0d", i), {26'd0, haz2, hold2, flush2, bub2, st2},
                {26'd0, vecs[i].exp});
            chk($sformatf("excl%0d", i), {31'd0, hold2 & flush2}, 32'd0);
            next_cycle();
        end

        // LOAD_LAT=3 load-use: three stall cycles, states 0,1,1,0
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        hz = 0;
        for (int c = 0; c < 4; c++) begin
            if (c < 3) drive(1, 4, 0, 0, 4, 1, 0, 0);
            else       drive(1, 0, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            if (haz3) hz++;
            chk($sformatf("lat3_state%0d", c), {30'd0, st3},
                (c == 1 || c == 2) ? 32'd1 : 32'd0);
            next_cycle();
        end
        chk("lat3_haz_cycles", hz, 32'd3);

        drive(1, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("lat3_jump_flush", {31'd0, flush3}, 32'd1);
        next_cycle();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
`ifdef HAZARD_PERF_CNT_EN
        chk("perf_stall_cnt", sc3, 32'd3);
        chk("perf_flush_cnt", fc3, 32'd1);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("perf_stall_clr", sc3, 32'd0);
        chk("perf_flush_clr", fc3, 32'd0);
`endif
        next_cycle();

        // LOAD_LAT=3 branch on second stall cycle aborts the stall
        hz = 0;
        drive(1, 6, 0, 0, 6, 1, 0, 0);
        @(negedge clk);
        if (haz3) hz++;
        chk("bst_c0_state", {30'd0, st3}, 32'd0);
        next_cycle();
        drive(1, 6, 0, 0, 6, 1, 1, 0);
        @(negedge clk);
        if (haz3) hz++;
        chk("bst_c1_outs", {28'd0, haz3, hold3, flush3, bub3}, 32'b0011);
        chk("bst_c1_state", {30'd0, st3}, 32'd1);
        next_cycle();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        if (haz3) hz++;
        chk("bst_c2_outs", {28'd0, haz3, hold3, flush3, bub3}, 32'b0001);
        chk("bst_c2_state", {30'd0, st3}, 32'd2);
        next_cycle();
        @(negedge clk);
        if (haz3) hz++;
        chk("bst_c3_state", {30'd0, st3}, 32'd0);
        chk("bst_haz_cycles", hz, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 32-bit pipelined CPU.
- Detects load-use data hazards and taken-branch / jump control hazards.
- Drives the fetch stage's `hazard` PC-hold input, the IF/ID hold and flush controls, and the ID/EX bubble control.
- Sits beside the ID stage and observes ID and EX pipeline-register fields.

Parameters:
- LOAD_LAT, 1, stall cycles inserted per load-use hazard; legal range 1..7.
- REG_AW, 5, register-specifier width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-low reset.
- id_rs  in  REG_AW  source register of the instruction in ID.
- id_rt  in  REG_AW  second source register of the instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt.
- ex_rd  in  REG_AW  destination register of the instruction in EX.
- ex_mem_read  in  1  EX instruction is a load.
- ex_branch_taken  in  1  branch in EX resolved taken (branch & zero_flag).
- id_jump  in  1  jump decoded in ID.
- pc_hazard  out  1  hold PC; connects to the fetch `hazard` input.
- ifid_hold  out  1  IF/ID register keeps its value.
- ifid_flush  out  1  IF/ID register loads a NOP.
- idex_bubble  out  1  ID/EX register loads a NOP.
- dbg_state  out  2  current FSM state.

Behaviour:
- Reset:
  - rst is sampled only at posedge clk; it is synchronous, active-low.
  - While rst==0, all control outputs are forced to 0.
  - At the next edge with rst==0: state<=RUN, cnt<=0.
  - A reset during STALL aborts the stall with no residual hold.
- Load-use condition (combinational):
  - lu = ex_mem_read & (ex_rd!=0) & ((ex_rd==id_rs) | (id_uses_rt & ex_rd==id_rt)).
  - A write to r0 never stalls.
- States (encoding): RUN=0, STALL=1, FLUSH=2.
- RUN, priority order:
  - ex_branch_taken:
    - Outputs: ifid_flush=1, idex_bubble=1, pc_hazard=0 (PC takes the branch target).
    - Next state: FLUSH.
  - else id_jump:
    - Outputs: ifid_flush=1, pc_hazard=0.
    - Next state: RUN.
  - else lu:
    - Outputs: pc_hazard=1, ifid_hold=1, idex_bubble=1, all in the same cycle (zero latency).
    - If LOAD_LAT>1: next state STALL, cnt<=LOAD_LAT-1.
    - If LOAD_LAT==1: stay in RUN.
  - else: all outputs 0.
- STALL:
  - Outputs: pc_hazard=1, ifid_hold=1, idex_bubble=1.
  - cnt decrements each cycle; when cnt==1, next state is RUN.
  - lu is ignored here, because EX holds a bubble.
  - ex_branch_taken overrides: flush outputs as in RUN, next state FLUSH, cnt<=0.
- FLUSH:
  - One cycle. Outputs: idex_bubble=1, which squashes the wrong-path instruction that was in ID.
  - Next state: RUN.
  - lu and id_jump are ignored in this cycle.
  - A new ex_branch_taken is impossible here (EX holds a bubble); if it is asserted anyway, treat it as in RUN.
- Mutual exclusion: ifid_hold and ifid_flush are never both 1.
- Total stall per load-use: exactly LOAD_LAT cycles of pc_hazard.
- Counter: 3 bits; no wrap is reachable within the legal LOAD_LAT range.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- With the macro defined:
  - Adds outputs stall_cnt[31:0] and flush_cnt[31:0].
  - stall_cnt increments every cycle that pc_hazard=1.
  - flush_cnt increments every cycle that ifid_flush=1.
  - Both clear on reset and wrap modulo 2^32.
- Without the macro: the ports and registers are absent; the rest of the behaviour is identical.

Decomposition:
- Shared package holds:
  - state typedef {RUN, STALL, FLUSH} with the fixed encodings above.
  - REG_AW default and a NOP instruction constant, both shared with the pipeline registers.
- Natural sub-module: hazard_detect, the purely combinational lu comparator. The FSM, counter and perf counters stay in hazard_ctrl.

Test Plan:
1. Reset: rst=0 for 2 cycles with lu and ex_branch_taken both driven high → all outputs 0, dbg_state=0. Release rst → normal operation resumes next cycle.
2. Load-use, LOAD_LAT=2: ex_mem_read=1, ex_rd=5, id_rs=5 → pc_hazard high for exactly 2 cycles, dbg_state 0→1→0. Repeat with ex_rd=0 → no stall.
3. rt dependence: ex_rd=7, id_rt=7 → stall when id_uses_rt=1; no stall when id_uses_rt=0.
4. Taken branch: ex_branch_taken=1 → ifid_flush=1 and idex_bubble=1 that cycle, idex_bubble=1 the next cycle, pc_hazard=0 throughout. Simultaneous id_jump and lu → branch wins.
5. Branch during stall, LOAD_LAT=3: on the 2nd stall cycle pulse ex_branch_taken → stall aborted, FLUSH entered; total pc_hazard cycles = 1.
6. Perf counters (HAZARD_PERF_CNT_EN): one load-use (LOAD_LAT=3) plus one jump → stall_cnt=3, flush_cnt=1. A mid-run reset clears both to 0.
